// File: rtl/seg_pkg.sv
// Shared types and sizes for the seven-segment scan controller.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEL_W      = 3;

    typedef logic [3:0]       digit_t;
    typedef logic [SEL_W-1:0] sel_t;

    // One scan state per displayed digit; the state value is the digit select.
    typedef enum logic [SEL_W-1:0] {
        SCAN_D0, SCAN_D1, SCAN_D2, SCAN_D3,
        SCAN_D4, SCAN_D5, SCAN_D6, SCAN_D7
    } scan_state_t;

endpackage

// File: rtl/seg_refresh_prescaler.sv
// Divides clk down to a one-cycle digit-slot tick every REFRESH_DIV enabled cycles.
module seg_refresh_prescaler #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // Terminal count doubles as the wrap point, so cnt never passes DIV-1.
    assign tick = en && (cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit time-multiplexed scan controller feeding num/sel to seg_display.
// Optional leading-zero blanking is compiled in with SEG_SCAN_LZB_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   wr_en,
    input  sel_t   wr_addr,
    input  digit_t wr_data,
    output digit_t num,
    output sel_t   sel,
    output logic   blank,
    output logic   frame_done
);

    logic        tick;
    scan_state_t state, state_nxt;
    sel_t        s_nxt;
    digit_t      mem [NUM_DIGITS];
    digit_t      num_nxt;
    logic        fd_nxt;

    seg_refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= SCAN_D0;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fd_nxt    = 1'b0;
        if (tick) begin
            state_nxt = scan_state_t'(sel_t'(state) + sel_t'(1));
            fd_nxt    = (state == SCAN_D7);
        end
    end

    assign s_nxt = sel_t'(state_nxt);
    assign sel   = sel_t'(state);

    // Load num from the digit that sel moves to, forwarding a same-cycle write.
    assign num_nxt = (wr_en && (wr_addr == s_nxt)) ? wr_data : mem[s_nxt];

    always_ff @(posedge clk) begin
        if (reset) begin
            num        <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++)
                mem[i] <= '0;
        end else begin
            num        <= num_nxt;
            frame_done <= fd_nxt;
            if (wr_en)
                mem[wr_addr] <= wr_data;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    digit_t eff [NUM_DIGITS];
    logic   blank_nxt;
    logic   blank_q;

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            eff[i] = (wr_en && (wr_addr == sel_t'(i))) ? wr_data : mem[i];
    end

    // Blank only if this digit and every more-significant digit are zero.
    always_comb begin
        blank_nxt = (s_nxt != '0);
        for (int j = 0; j < NUM_DIGITS; j++)
            if ((sel_t'(j) >= s_nxt) && (eff[j] != '0))
                blank_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            blank_q <= 1'b0;
        else
            blank_q <= blank_nxt;
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

endmodule
